snake_dir_ctrl: RTL and testbench

//  Per-player direction controller for the snake game. Conditions the four raw direction buttons.

---
 rtl/snake_pkg.sv | 51 +++++
 rtl/snake_btn_cond.sv | 72 +++++++
 rtl/snake_dir_ctrl.sv | 146 ++++++++++++++
 tb/tb_snake_dir_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake game direction path.
// Contents:
//   dir_t     : one-hot direction code, R=10000 D=01000 L=00100 U=00010 STOP=00001
//   btn_e     : index of each raw button in the per-player press vector
//   opposite(): 180-degree reversal of a direction, also used by movement/collision
//   btn_dir() : direction a given button requests
package snake_pkg;

    typedef logic [4:0] dir_t;

    localparam dir_t DIR_R    = 5'b10000;
    localparam dir_t DIR_D    = 5'b01000;
    localparam dir_t DIR_L    = 5'b00100;
    localparam dir_t DIR_U    = 5'b00010;
    localparam dir_t DIR_STOP = 5'b00001;

    typedef enum logic [1:0] {
        BTN_U = 2'd0,
        BTN_L = 2'd1,
        BTN_D = 2'd2,
        BTN_R = 2'd3
    } btn_e;

    localparam int unsigned NUM_BTN = 4;
    localparam int unsigned QMAX    = 4;

    // STOP has no opposite; returning STOP keeps it from ever matching a real turn.
    function automatic dir_t opposite(input dir_t d);
        dir_t o;
        case (d)
            DIR_R:   o = DIR_L;
            DIR_L:   o = DIR_R;
            DIR_U:   o = DIR_D;
            DIR_D:   o = DIR_U;
            default: o = DIR_STOP;
        endcase
        return o;
    endfunction

    function automatic dir_t btn_dir(input btn_e b);
        dir_t o;
        case (b)
            BTN_U:   o = DIR_U;
            BTN_L:   o = DIR_L;
            BTN_D:   o = DIR_D;
            default: o = DIR_R;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/snake_btn_cond.sv
// Conditions one raw direction button into a single-cycle press pulse.
// Ports:
//   clk   in  system clock
//   rst   in  asynchronous active-high reset
//   pin   in  raw button, asynchronous to clk
//   press out one-cycle pulse per press, registered
// Build option SNAKE_DIR_DEBOUNCE_EN: the synchronized level must stay high for
// DEB_CYCLES consecutive clocks before it counts as pressed (latency 3+DEB_CYCLES);
// otherwise the latency is 3 clocks.
module snake_btn_cond
`ifdef SNAKE_DIR_DEBOUNCE_EN
#(
    parameter int unsigned DEB_CYCLES = 50000
)
`endif
(
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic press
);

    logic       s1;
    logic       s2;
    logic       prev;
    logic       armed;
    logic [1:0] warm;
    logic       lvl;

`ifdef SNAKE_DIR_DEBOUNCE_EN
    localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
    logic [CW-1:0] cnt;

    assign lvl = (cnt == CW'(DEB_CYCLES));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!s2) begin
            cnt <= '0;
        end else if (!lvl) begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    assign lvl = s2;
`endif

    // A button held through reset must not fire on reset release: the edge
    // detector only arms once the synchronized pin has been seen low after the
    // synchronizer has filled with real samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            prev  <= 1'b0;
            armed <= 1'b0;
            warm  <= '0;
            press <= 1'b0;
        end else begin
            s1    <= pin;
            s2    <= s1;
            warm  <= {warm[0], 1'b1};
            if (warm[1] && !s2) begin
                armed <= 1'b1;
            end
            prev  <= lvl;
            press <= armed && lvl && !prev;
        end
    end

endmodule

// File: rtl/snake_dir_ctrl.sv
// Per-player direction controller: conditions the four direction buttons,
// rejects repeat and reversal turns, queues legal turns, and commits one
// queued turn per game-step tick.
// Ports:
//   clk      in  system clock
//   rst      in  asynchronous active-high reset
//   U,D,R,L  in  raw direction buttons
//   tick     in  one-cycle game-step strobe
//   dir2     out committed one-hot direction (STOP after reset)
//   dir_upd  out one-cycle pulse alongside each new dir2
//   q_cnt    out turns currently queued
//   q_ovf    out sticky: a legal turn was dropped on a full queue
// Parameters: QDEPTH (1..4), DEB_CYCLES (debounce build only).
// Build option SNAKE_DIR_DEBOUNCE_EN enables the per-button debounce counters.
module snake_dir_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned QDEPTH     = 2,
    parameter int unsigned DEB_CYCLES = 50000
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       U,
    input  logic       D,
    input  logic       R,
    input  logic       L,
    input  logic       tick,
    output dir_t       dir2,
    output logic       dir_upd,
    output logic [2:0] q_cnt,
    output logic       q_ovf
);

    if (QDEPTH < 1 || QDEPTH > QMAX) begin : g_bad_qdepth
        $error("snake_dir_ctrl: QDEPTH must be 1..4");
    end
    if (DEB_CYCLES < 1) begin : g_bad_deb
        $error("snake_dir_ctrl: DEB_CYCLES must be at least 1");
    end

    logic [NUM_BTN-1:0] pin;
    logic [NUM_BTN-1:0] press;

    assign pin[BTN_U] = U;
    assign pin[BTN_L] = L;
    assign pin[BTN_D] = D;
    assign pin[BTN_R] = R;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
`ifdef SNAKE_DIR_DEBOUNCE_EN
        snake_btn_cond #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_cond (
            .clk   (clk),
            .rst   (rst),
            .pin   (pin[i]),
            .press (press[i])
        );
`else
        snake_btn_cond u_cond (
            .clk   (clk),
            .rst   (rst),
            .pin   (pin[i]),
            .press (press[i])
        );
`endif
    end

    // Queue storage is sized for the largest legal depth so the 2-bit
    // pointers index it exactly; only the first QDEPTH slots are used.
    dir_t       q [QMAX];
    logic [1:0] head;
    logic [1:0] tail;
    logic [1:0] last;

    dir_t ev;
    logic ev_vld;
    dir_t ref_dir;
    logic legal;
    logic pop;
    logic push;
    logic drop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(QDEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    // Same-cycle presses: U > L > D > R, the rest are discarded.
    always_comb begin
        ev     = DIR_STOP;
        ev_vld = 1'b0;
        if (press[BTN_U]) begin
            ev     = btn_dir(BTN_U);
            ev_vld = 1'b1;
        end else if (press[BTN_L]) begin
            ev     = btn_dir(BTN_L);
            ev_vld = 1'b1;
        end else if (press[BTN_D]) begin
            ev     = btn_dir(BTN_D);
            ev_vld = 1'b1;
        end else if (press[BTN_R]) begin
            ev     = btn_dir(BTN_R);
            ev_vld = 1'b1;
        end
    end

    always_comb begin
        last    = (tail == 2'd0) ? 2'(QDEPTH - 1) : tail - 2'd1;
        ref_dir = (q_cnt != 3'd0) ? q[last] : dir2;
        legal   = ev_vld && (ev != ref_dir) && (ev != opposite(ref_dir));
        pop     = tick && (q_cnt != 3'd0);
        // When full, the slot being popped this cycle is the one written.
        push    = legal && ((q_cnt < 3'(QDEPTH)) || pop);
        drop    = legal && !push;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < QMAX; i++) begin
                q[i] <= '0;
            end
            head    <= '0;
            tail    <= '0;
            q_cnt   <= '0;
            q_ovf   <= 1'b0;
            dir2    <= DIR_STOP;
            dir_upd <= 1'b0;
        end else begin
            dir_upd <= pop;
            if (pop) begin
                dir2 <= q[head];
                head <= ptr_inc(head);
            end
            if (push) begin
                q[tail] <= ev;
                tail    <= ptr_inc(tail);
            end
            if (drop) begin
                q_ovf <= 1'b1;
            end
            q_cnt <= q_cnt + {2'b00, push} - {2'b00, pop};
        end
    end

endmodule

// File: tb/tb_snake_dir_ctrl.sv
module tb_snake_dir_ctrl;

    localparam int unsigned QDEPTH = 2;
`ifdef SNAKE_DIR_DEBOUNCE_EN
    localparam int unsigned DEB = 8;
    localparam int unsigned LAT = 3 + DEB;
`else
    localparam int unsigned DEB = 50000;
    localparam int unsigned LAT = 3;
`endif

    localparam logic [4:0] R_ = 5'b10000;
    localparam logic [4:0] D_ = 5'b01000;
    localparam logic [4:0] L_ = 5'b00100;
    localparam logic [4:0] U_ = 5'b00010;
    localparam logic [4:0] S_ = 5'b00001;

    logic       clk = 1'b0;
    logic       rst;
    logic       bu, bd, br, bl;
    logic       tick;
    logic [4:0] dir2;
    logic       dir_upd;
    logic [2:0] q_cnt;
    logic       q_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    snake_dir_ctrl #(
        .QDEPTH     (QDEPTH),
        .DEB_CYCLES (DEB)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .U       (bu),
        .D       (bd),
        .R       (br),
        .L       (bl),
        .tick    (tick),
        .dir2    (dir2),
        .dir_upd (dir_upd),
        .q_cnt   (q_cnt),
        .q_ovf   (q_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_pin(input int b, input logic v);
        case (b)
            0: bu = v;
            1: bl = v;
            2: bd = v;
            default: br = v;
        endcase
    endtask

    // Full press/release; returns at a negedge after the event has been taken.
    task automatic press(input int b);
        set_pin(b, 1'b1);
        repeat (LAT + 1) @(posedge clk);
        @(negedge clk);
        set_pin(b, 1'b0);
        repeat (4) @(negedge clk);
    endtask

    task automatic do_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_dir2"}, 32'(dir2), 32'(S_));
        check({tag, "_upd"}, 32'(dir_upd), 32'd0);
        check({tag, "_qcnt"}, 32'(q_cnt), 32'd0);
        check({tag, "_qovf"}, 32'(q_ovf), 32'd0);
    endtask

    initial begin
        rst = 1'b1; bu = 0; bd = 0; br = 0; bl = 0; tick = 0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        rst = 1'b0;
        repeat (6) @(negedge clk);

        // 1: R then tick
        press(3);
        check("t1_qcnt_push", 32'(q_cnt), 32'd1);
        do_tick();
        check("t1_dir2", 32'(dir2), 32'(R_));
        check("t1_upd", 32'(dir_upd), 32'd1);
        check("t1_qcnt_pop", 32'(q_cnt), 32'd0);
        @(negedge clk);
        check("t1_upd_low", 32'(dir_upd), 32'd0);

        // 2: reversal and repeat rejected
        press(1);
        check("t2_rev_qcnt", 32'(q_cnt), 32'd0);
        press(3);
        check("t2_rep_qcnt", 32'(q_cnt), 32'd0);
        do_tick();
        check("t2_dir2", 32'(dir2), 32'(R_));
        check("t2_upd", 32'(dir_upd), 32'd0);

        // 3: U then L queued, two ticks
        press(0);
        press(1);
        check("t3_qcnt", 32'(q_cnt), 32'd2);
        do_tick();
        check("t3_dir2_a", 32'(dir2), 32'(U_));
        check("t3_upd_a", 32'(dir_upd), 32'd1);
        check("t3_qcnt_a", 32'(q_cnt), 32'd1);
        do_tick();
        check("t3_dir2_b", 32'(dir2), 32'(L_));
        check("t3_qcnt_b", 32'(q_cnt), 32'd0);

        // 4: full queue drop, then push alongside pop
        press(0);
        press(1);
        check("t4_full", 32'(q_cnt), 32'd2);
        check("t4_ovf_pre", 32'(q_ovf), 32'd0);
        press(2);
        check("t4_drop_qcnt", 32'(q_cnt), 32'd2);
        check("t4_ovf", 32'(q_ovf), 32'd1);
        bd = 1'b1;
        repeat (LAT) @(posedge clk);
        @(negedge clk);
        do_tick();
        check("t4_pp_qcnt", 32'(q_cnt), 32'd2);
        check("t4_pp_dir2", 32'(dir2), 32'(U_));
        check("t4_pp_upd", 32'(dir_upd), 32'd1);
        bd = 1'b0;
        repeat (4) @(negedge clk);
        check("t4_ovf_sticky", 32'(q_ovf), 32'd1);
        do_tick();
        check("t4_dir2_l", 32'(dir2), 32'(L_));
        do_tick();
        check("t4_dir2_d", 32'(dir2), 32'(D_));
        check("t4_qcnt_empty", 32'(q_cnt), 32'd0);
        do_tick();
        check("t4_empty_dir2", 32'(dir2), 32'(D_));
        check("t4_empty_upd", 32'(dir_upd), 32'd0);

        // 5: U and R together from STOP
        do_reset();
        check_reset_vals("t5_rst");
        bu = 1'b1; br = 1'b1;
        repeat (LAT + 1) @(posedge clk);
        @(negedge clk);
        bu = 1'b0; br = 1'b0;
        repeat (4) @(negedge clk);
        check("t5_qcnt", 32'(q_cnt), 32'd1);
        do_tick();
        check("t5_dir2", 32'(dir2), 32'(U_));
        check("t5_qcnt_pop", 32'(q_cnt), 32'd0);

        // 6: held U, reset mid-queue
        do_reset();
        bu = 1'b1;
        repeat (LAT + 1) @(posedge clk);
        @(negedge clk);
        check("t6_u_qcnt", 32'(q_cnt), 32'd1);
        press(1);
        check("t6_ul_qcnt", 32'(q_cnt), 32'd2);
        repeat (1000) @(negedge clk);
        check("t6_hold_qcnt", 32'(q_cnt), 32'd2);
        check("t6_hold_ovf", 32'(q_ovf), 32'd0);
        #3 rst = 1'b1;
        #1 check_reset_vals("t6_async");
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check_reset_vals("t6_post");
        bu = 1'b0;
        repeat (6) @(negedge clk);
        press(2);
        check("t6_fresh_qcnt", 32'(q_cnt), 32'd1);

`ifdef SNAKE_DIR_DEBOUNCE_EN
        // glitch shorter than the debounce window
        bl = 1'b1;
        repeat (5) @(negedge clk);
        bl = 1'b0;
        repeat (20) @(negedge clk);
        check("deb_glitch_qcnt", 32'(q_cnt), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
